// File: rtl/irq_event_source.sv
// Peripheral end of the raw-interrupt handshake: event rising edges become level
// interrupts, cleared or re-armed by toggles on irq_rearm, with coalesced-event counting.
module irq_event_source #(
  parameter int DATAWIDTH  = 1,
  parameter int CNTWIDTH   = 4,
  parameter bit SYNC_REARM = 1'b1
) (
  input  logic                          bus_clk,
  input  logic                          bus_reset_l,
  // 'event' is a reserved word in SystemVerilog, hence 'evt'.
  input  logic [DATAWIDTH-1:0]          evt,
  input  logic [DATAWIDTH-1:0]          irq_rearm,
  output logic [DATAWIDTH-1:0]          irq,
  output logic [DATAWIDTH*CNTWIDTH-1:0] missed,
  output logic [DATAWIDTH-1:0]          ovf
);

  typedef enum logic {
    ARMED = 1'b0,
    PEND  = 1'b1
  } state_e;

  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

  state_e              state_q [DATAWIDTH];
  state_e              state_d [DATAWIDTH];
  logic [CNTWIDTH-1:0] cnt_q   [DATAWIDTH];
  logic [CNTWIDTH-1:0] cnt_d   [DATAWIDTH];
  logic [DATAWIDTH-1:0] ovf_q, ovf_d;
  logic [DATAWIDTH-1:0] ev_q, rise, rearm;

  assign rise = evt & ~ev_q;

  // History flops reset to 0, the rearm source's own reset value, so no toggle
  // is seen coming out of reset.
  if (SYNC_REARM) begin : g_sync_rearm
    logic [DATAWIDTH-1:0] s1, s2, r_q;

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) begin
        s1  <= '0;
        s2  <= '0;
        r_q <= '0;
      end else begin
        s1  <= irq_rearm;
        s2  <= s1;
        r_q <= s2;
      end
    end

    assign rearm = s2 ^ r_q;
  end else begin : g_direct_rearm
    logic [DATAWIDTH-1:0] r_q;

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) r_q <= '0;
      else              r_q <= irq_rearm;
    end

    assign rearm = irq_rearm ^ r_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      ev_q  <= '0;
      ovf_q <= '0;
      for (int i = 0; i < DATAWIDTH; i++) begin
        state_q[i] <= ARMED;
        cnt_q[i]   <= '0;
      end
    end else begin
      ev_q  <= evt;
      ovf_q <= ovf_d;
      for (int i = 0; i < DATAWIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the branches below can infer a latch.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < DATAWIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (state_q[i] == ARMED) begin
        // A rearm while armed is spurious and ignored.
        if (rise[i]) state_d[i] = PEND;
      end else if (rise[i] && rearm[i]) begin
        // The fresh event replaces whatever was coalesced before.
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (rise[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rearm[i]) begin
        // Coalesced events, if any, become the next interrupt.
        if (cnt_q[i] == '0) begin
          state_d[i] = ARMED;
        end else begin
          cnt_d[i] = '0;
          ovf_d[i] = 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < DATAWIDTH; i++) begin : g_out
    assign irq[i]                          = (state_q[i] == PEND);
    assign missed[i*CNTWIDTH +: CNTWIDTH]  = cnt_q[i];
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_irq_event_source.sv
// Directed bench for irq_event_source: a 2-channel synchronized-rearm instance and a
// 1-channel direct-rearm instance, checked against a queue of expected output words.
module tb_irq_event_source;

  logic       bus_clk = 1'b0;
  logic       bus_reset_l;
  logic [1:0] evt, irq_rearm, irq, ovf;
  logic [3:0] missed;
  logic [0:0] evt0, rearm0, irq0, ovf0;
  logic [1:0] missed0;

  int errors = 0;
  int checks = 0;

  // Scoreboard: bit 8 selects the direct-rearm instance, bits 7:0 the expected word.
  string      tag_q[$];
  logic [8:0] exp_q[$];

  always #5 bus_clk = ~bus_clk;

  irq_event_source #(.DATAWIDTH(2), .CNTWIDTH(2), .SYNC_REARM(1'b1)) dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .evt         (evt),
    .irq_rearm   (irq_rearm),
    .irq         (irq),
    .missed      (missed),
    .ovf         (ovf)
  );

  irq_event_source #(.DATAWIDTH(1), .CNTWIDTH(2), .SYNC_REARM(1'b0)) dut0 (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .evt         (evt0),
    .irq_rearm   (rearm0),
    .irq         (irq0),
    .missed      (missed0),
    .ovf         (ovf0)
  );

  function automatic logic [7:0] pk(logic [1:0] i, logic [1:0] m1, logic [1:0] m0,
                                    logic [1:0] o);
    return {i, m1, m0, o};
  endfunction

  task automatic expect_out(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back({1'b0, v});
  endtask

  task automatic expect0(input string tag, input logic [3:0] v);
    tag_q.push_back(tag);
    exp_q.push_back({1'b1, 4'b0000, v});
  endtask

  task automatic check();
    logic [8:0] e;
    logic [7:0] obs;
    string      t;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = e[8] ? {4'b0000, irq0, missed0, ovf0} : {irq, missed, ovf};
      checks++;
      assert (obs === e[7:0]) else begin
        errors++;
        $error("FAIL %s: observed {irq,missed,ovf}=%b expected=%b", t, obs, e[7:0]);
      end
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge bus_clk);
  endtask

  task automatic pulse(input logic [1:0] m);
    evt = m;
    step();
    evt = 2'b00;
  endtask

  task automatic toggle(input logic [1:0] m);
    irq_rearm = irq_rearm ^ m;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_reset_l = 1'b0;
    evt         = 2'b11;
    irq_rearm   = 2'b11;
    evt0        = 1'b0;
    rearm0      = 1'b0;
    step(2);
    expect_out("reset_hold", 8'h00);
    check();

    // Release reset; the rearm source returns to its reset-time-consistent value.
    bus_reset_l = 1'b1;
    irq_rearm   = 2'b00;
    #1;
    expect_out("reset_release", 8'h00);
    check();
    expect_out("first_event_after_reset", pk(2'b11, 2'd0, 2'd0, 2'b00));
    step();
    check();
    step(4);
    expect_out("no_rearm_from_reset", pk(2'b11, 2'd0, 2'd0, 2'b00));
    check();

    // Rearm latency through the synchronizer: irq falls on the third edge.
    toggle(2'b11);
    step(2);
    expect_out("rearm_edge2_still_pending", pk(2'b11, 2'd0, 2'd0, 2'b00));
    check();
    step();
    expect_out("rearm_edge3_cleared", 8'h00);
    check();
    evt = 2'b00;
    step();

    // Basic single pulse on ch0.
    expect_out("ch0_pulse", pk(2'b01, 2'd0, 2'd0, 2'b00));
    pulse(2'b01);
    check();
    toggle(2'b01);
    step(2);
    expect_out("ch0_rearm_edge2", pk(2'b01, 2'd0, 2'd0, 2'b00));
    check();
    step();
    expect_out("ch0_rearm_edge3", 8'h00);
    check();

    // Held-high event yields exactly one interrupt.
    evt = 2'b01;
    step();
    expect_out("held_first", pk(2'b01, 2'd0, 2'd0, 2'b00));
    check();
    step(5);
    expect_out("held_no_count", pk(2'b01, 2'd0, 2'd0, 2'b00));
    check();
    toggle(2'b01);
    step(3);
    expect_out("held_cleared", 8'h00);
    check();
    step(3);
    expect_out("held_no_second_irq", 8'h00);
    check();
    evt = 2'b00;
    step();

    // Coalescing and saturation on ch1.
    expect_out("ch1_pulse", pk(2'b10, 2'd0, 2'd0, 2'b00));
    pulse(2'b10);
    check();
    step(2);
    for (int k = 1; k <= 3; k++) begin
      expect_out($sformatf("ch1_coalesce_%0d", k), pk(2'b10, 2'(k), 2'd0, 2'b00));
      pulse(2'b10);
      check();
      step(2);
    end
    expect_out("ch1_saturate_ovf", pk(2'b10, 2'd3, 2'd0, 2'b10));
    pulse(2'b10);
    check();
    toggle(2'b10);
    step(2);
    expect_out("ch1_rearm_not_yet", pk(2'b10, 2'd3, 2'd0, 2'b10));
    check();
    step();
    expect_out("ch1_coalesced_stays", pk(2'b10, 2'd0, 2'd0, 2'b00));
    check();
    toggle(2'b10);
    step(3);
    expect_out("ch1_second_rearm", 8'h00);
    check();

    // Event rise in the same cycle as the synchronized rearm pulse.
    pulse(2'b01);
    step(2);
    pulse(2'b01);
    step(2);
    expect_out("ch0_missed2", pk(2'b01, 2'd0, 2'd2, 2'b00));
    pulse(2'b01);
    check();
    step(2);
    toggle(2'b01);
    step(2);
    evt = 2'b01;
    expect_out("simul_rise_rearm", pk(2'b01, 2'd0, 2'd0, 2'b00));
    step();
    check();
    evt = 2'b00;
    toggle(2'b01);
    step(3);
    expect_out("simul_clear", 8'h00);
    check();
    toggle(2'b01);
    step(4);
    expect_out("spurious_while_armed", 8'h00);
    check();

    // Channel independence.
    expect_out("indep_ch0_pulse", pk(2'b01, 2'd0, 2'd0, 2'b00));
    pulse(2'b01);
    check();
    toggle(2'b10);
    step(4);
    expect_out("indep_ch1_rearm_only", pk(2'b01, 2'd0, 2'd0, 2'b00));
    check();
    toggle(2'b01);
    step(3);
    expect_out("indep_clear", 8'h00);
    check();

    // Direct (unsynchronized) rearm instance: one-edge latency.
    evt0 = 1'b1;
    expect0("nosync_pulse", 4'b1000);
    step();
    check();
    evt0 = 1'b0;
    rearm0 = 1'b1;
    expect0("nosync_rearm_1edge", 4'b0000);
    step();
    check();
    evt0 = 1'b1;
    step();
    evt0 = 1'b0;
    step();
    evt0 = 1'b1;
    step();
    evt0 = 1'b0;
    expect0("nosync_missed1", 4'b1010);
    check();
    rearm0 = 1'b0;
    step();
    expect0("nosync_coalesced", 4'b1000);
    check();
    rearm0 = 1'b1;
    step();
    expect0("nosync_cleared", 4'b0000);
    check();

    // Reset mid-operation with a rearm toggle inside the synchronizer.
    for (int k = 0; k < 5; k++) begin
      pulse(2'b01);
      step(2);
    end
    expect_out("pre_reset_state", pk(2'b01, 2'd0, 2'd3, 2'b01));
    check();
    toggle(2'b01);
    step();
    #2;
    bus_reset_l = 1'b0;
    #1;
    expect_out("async_reset_immediate", 8'h00);
    check();
    @(negedge bus_clk);
    bus_reset_l = 1'b1;
    step(4);
    expect_out("post_reset_no_rearm", 8'h00);
    check();
    expect_out("post_reset_pulse", pk(2'b01, 2'd0, 2'd0, 2'b00));
    pulse(2'b01);
    check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
